speed_ramp: RTL and testbench
=============================

// Module: speed_ramp
// PURPOSE
//   Acceleration-limited setpoint generator upstream of speedblock: accepts left/right
//   target speeds over a valid/ready handshake and drives speedL_o/speedR_o (to
//   speedblock.speedL_i/speedR_i). Setpoints move toward the targets by at most `accel`
//   counts per ramp tick, so a step command never reaches the speed PIDs directly.
//   Deasserting en forces a controlled ramp-down to zero.
// PARAMETERS
//   clk_freq   48000000  system clock frequency in Hz (SB_HFOSC)
//   ramp_freq  1000      ramp update rate in Hz; divider = clk_freq/ramp_freq (integer, >=2)
//   speed_res  16        width of signed speed values (two's complement)
//   accel      8         maximum setpoint change per tick, >0
//   vmax       16000     target clamp magnitude, 0 < vmax < 2^(speed_res-1)
// PORTS
//   clk          in   1          system clock, all state on rising edge
//   rst          in   1          asynchronous, active-high reset
//   clr          in   1          synchronous clear: same effect as rst, on next edge
//   en           in   1          1 = track targets; 0 = brake to zero, refuse commands
//   tgtL_i       in   speed_res  signed left target
//   tgtR_i       in   speed_res  signed right target
//   tgt_valid_i  in   1          target pair valid
//   tgt_ready_o  out  1          target pair accepted on edge where valid & ready
//   speedL_o     out  speed_res  signed left setpoint (registered)
//   speedR_o     out  speed_res  signed right setpoint (registered)
//   busy_o       out  1          1 while any setpoint differs from its target
//   tick_o       out  1          one-cycle pulse on each ramp update
// BEHAVIOUR
// - Reset (rst async or clr sync): speedL_o=speedR_o=0, latched targets=0, divider=0,
//   state=IDLE, tick_o=0, busy_o=0, tgt_ready_o=1 (combinational from state/en).
// - Divider counts 0..clk_freq/ramp_freq-1, wraps; tick_o=1 during the cycle the counter
//   equals its terminal value. Runs regardless of en or state; first tick after reset
//   is at cycle clk_freq/ramp_freq.
// - Handshake: tgt_ready_o = en & (state != BRAKE). On valid & ready edge, each target is
//   clamped to [-vmax, +vmax] and latched. valid with ready low: pair is dropped, no effect.
//   Latest accepted pair wins; retargeting mid-ramp is allowed.
// - Ramp step, evaluated only on tick edges, per channel independently:
//   diff = tgt - cur in speed_res+1 bits; if |diff| <= accel then cur <= tgt,
//   else cur <= cur + accel (diff>0) or cur - accel (diff<0). Output changes the edge
//   after tick_o is seen high (i.e. registered at the terminal-count edge).
// - Accept and tick on same edge: step uses the OLD latched targets; new ones take effect
//   on the following tick.
// - FSM: IDLE  (speedL_o==tgtL and speedR_o==tgtR)
//          -> RAMP on accept of a pair differing from current setpoints
//          -> BRAKE when en=0 and either setpoint nonzero
//        RAMP  -> IDLE when both channels reach their targets on a tick
//          -> BRAKE when en=0
//        BRAKE: latched targets forced to 0 on entry; ramps both to 0; -> IDLE when both
//          are 0. In IDLE with en=0 ready stays 0; targets remain 0.
//   busy_o = (state != IDLE).
// - No overflow possible: |cur| <= vmax and accel steps never overshoot the target.
// TESTING (clk_freq=1000, ramp_freq=100 -> tick every 10 cycles; accel=8, vmax=1000)
// 1. Reset/idle: assert rst -> speeds 0, busy_o 0, tgt_ready_o 1; tick_o every 10th cycle.
// 2. Step: accept L=100, R=-50 -> L 8,16..96,100 (13th tick), R -8..-48,-50 (7th tick);
//    busy_o falls the cycle after L reaches 100.
// 3. Clamp: accept L=5000, R=-5000 -> targets 1000/-1000; L reaches 1000 on tick 125.
// 4. Retarget mid-ramp: at L=40 accept L=0 -> next ticks 32,24,16,8,0; accept coincident
//    with a tick -> that tick still steps toward old target.
// 5. Brake: L=100 steady, drop en -> tgt_ready_o 0, valid pairs ignored, L reaches 0 in 13
//    ticks, busy_o 0; raise en -> tgt_ready_o 1, new command ramps normally.
// 6. Reset mid-ramp: rst asynchronously at L=48 -> speedL_o 0 before next clk edge,
//    divider restarts, first tick 10 cycles after release; clr gives same result on edge.

Source files
------------

// File: rtl/speed_ramp.sv
// speed_ramp: acceleration-limited left/right speed setpoint generator.
// Targets arrive over valid/ready, are clamped to +/-vmax, and the registered
// setpoints slew toward them by at most accel counts per ramp tick. Dropping
// en brakes both channels to zero and refuses new commands until they stop.
module speed_ramp #(
  parameter int clk_freq  = 48000000,
  parameter int ramp_freq = 1000,
  parameter int speed_res = 16,
  parameter int accel     = 8,
  parameter int vmax      = 16000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [speed_res-1:0] tgtL_i,
  input  logic [speed_res-1:0] tgtR_i,
  input  logic                 tgt_valid_i,
  output logic                 tgt_ready_o,
  output logic [speed_res-1:0] speedL_o,
  output logic [speed_res-1:0] speedR_o,
  output logic                 busy_o,
  output logic                 tick_o
);

  localparam int unsigned div = clk_freq / ramp_freq;
  localparam int          cw  = $clog2(div);
  localparam logic [cw-1:0] term = cw'(div - 1);

  localparam logic signed [speed_res-1:0] vpos    = speed_res'(vmax);
  localparam logic signed [speed_res-1:0] vneg    = speed_res'(-vmax);
  localparam logic signed [speed_res-1:0] step_sz = speed_res'(accel);
  localparam logic signed [speed_res:0]   lim_p   = (speed_res+1)'(accel);
  localparam logic signed [speed_res:0]   lim_n   = (speed_res+1)'(-accel);

  typedef enum logic [1:0] {IDLE, RAMP, BRAKE} state_t;

  state_t               state, state_n;
  logic [cw-1:0]        cnt;
  logic [speed_res-1:0] tgt_l, tgt_r;
  logic [speed_res-1:0] step_l, step_r;
  logic [speed_res-1:0] clamp_l, clamp_r;
  logic                 accept;

  // Limit a signed target to [-vmax, +vmax].
  function automatic logic [speed_res-1:0] clamp(input logic [speed_res-1:0] v);
    logic signed [speed_res-1:0] s;
    s = $signed(v);
    if (s > vpos) return vpos;
    if (s < vneg) return vneg;
    return v;
  endfunction

  // One ramp step of cur toward tgt; difference taken one bit wider so it never wraps.
  function automatic logic [speed_res-1:0] step_to(input logic [speed_res-1:0] cur,
                                                   input logic [speed_res-1:0] tgt);
    logic signed [speed_res:0] diff;
    diff = $signed({tgt[speed_res-1], tgt}) - $signed({cur[speed_res-1], cur});
    if (diff <= lim_p && diff >= lim_n) return tgt;
    if (!diff[speed_res]) return cur + step_sz;
    return cur - step_sz;
  endfunction

  assign tick_o      = (cnt == term);
  assign busy_o      = (state != IDLE);
  assign tgt_ready_o = en && (state != BRAKE);

  // Candidate step values, clamped inputs and handshake acceptance.
  always_comb begin
    step_l  = step_to(speedL_o, tgt_l);
    step_r  = step_to(speedR_o, tgt_r);
    clamp_l = clamp(tgtL_i);
    clamp_r = clamp(tgtR_i);
    accept  = tgt_valid_i && tgt_ready_o;
  end

  // Free-running ramp divider, wraps at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!en && (speedL_o != '0 || speedR_o != '0)) begin
          state_n = BRAKE;
        end else if (accept && (clamp_l != speedL_o || clamp_r != speedR_o)) begin
          state_n = RAMP;
        end
      end
      RAMP: begin
        // A pair accepted on the arrival tick keeps RAMP; the next tick settles it.
        if (!en) begin
          state_n = BRAKE;
        end else if (tick_o && step_l == tgt_l && step_r == tgt_r && !accept) begin
          state_n = IDLE;
        end
      end
      BRAKE: begin
        if (tick_o && step_l == '0 && step_r == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Setpoints step on ticks with the currently latched targets; targets latch on accept
  // and are zeroed when braking starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speedL_o <= '0;
      speedR_o <= '0;
      tgt_l    <= '0;
      tgt_r    <= '0;
    end else if (clr) begin
      speedL_o <= '0;
      speedR_o <= '0;
      tgt_l    <= '0;
      tgt_r    <= '0;
    end else begin
      if (tick_o) begin
        speedL_o <= step_l;
        speedR_o <= step_r;
      end
      if (state_n == BRAKE && state != BRAKE) begin
        tgt_l <= '0;
        tgt_r <= '0;
      end else if (accept) begin
        tgt_l <= clamp_l;
        tgt_r <= clamp_r;
      end
    end
  end

endmodule

// File: tb/tb_speed_ramp.sv
// Directed bench for speed_ramp: expected setpoints per tick are queued when a
// command is issued and popped/compared after each ramp tick edge.
module tb_speed_ramp;

  localparam int ACC  = 8;
  localparam int VMAX = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        en  = 1'b1;
  logic [15:0] tgt_l = '0;
  logic [15:0] tgt_r = '0;
  logic        tgt_valid = 1'b0;
  logic        tgt_ready;
  logic [15:0] speed_l, speed_r;
  logic        busy, tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [31:0] l;
    logic signed [31:0] r;
    logic               busy;
  } exp_t;

  exp_t q[$];

  speed_ramp #(
    .clk_freq (1000),
    .ramp_freq(100),
    .speed_res(16),
    .accel    (ACC),
    .vmax     (VMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (en),
    .tgtL_i     (tgt_l),
    .tgtR_i     (tgt_r),
    .tgt_valid_i(tgt_valid),
    .tgt_ready_o(tgt_ready),
    .speedL_o   (speed_l),
    .speedR_o   (speed_r),
    .busy_o     (busy),
    .tick_o     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for a tick cycle, then step past its edge; bounded.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tick) begin
        cyc();
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic send(input int l, input int r);
    tgt_l     = 16'(l);
    tgt_r     = 16'(r);
    tgt_valid = 1'b1;
    cyc();
    tgt_valid = 1'b0;
  endtask

  function automatic int toward(input int c, input int t);
    if (t > c) return (t - c <= ACC) ? t : c + ACC;
    if (t < c) return (c - t <= ACC) ? t : c - ACC;
    return c;
  endfunction

  // Queue the per-tick setpoints of a ramp; n limits the count (0 = until arrival).
  task automatic push_ramp(input int l0, input int lt, input int r0, input int rt,
                           input int n);
    int l, r, k;
    l = l0; r = r0; k = 0;
    while ((l != lt || r != rt) && (n == 0 || k < n)) begin
      l = toward(l, lt);
      r = toward(r, rt);
      k++;
      q.push_back('{l, r, (l != lt || r != rt)});
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_nonempty", 0, 1);
      return;
    end
    e = q.pop_front();
    chk("speedL", $signed(speed_l), e.l);
    chk("speedR", $signed(speed_r), e.r);
    chk("busy", busy, e.busy);
  endtask

  task automatic check_tick();
    bit ok;
    wait_tick(ok);
    chk("tick_seen", ok, 1);
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_speedL", $signed(speed_l), 0);
    chk("rst_speedR", $signed(speed_r), 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_tick", tick, 0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("div_tick", tick, (k % 10 == 9));
    end

    // Step command
    chk("step_ready", tgt_ready, 1);
    send(100, -50);
    chk("step_busy", busy, 1);
    push_ramp(0, 100, 0, -50, 0);
    repeat (13) check_tick();

    // Brake
    en = 1'b0;
    #1;
    chk("brake_ready", tgt_ready, 0);
    tgt_l = 16'(500);
    tgt_r = 16'(500);
    tgt_valid = 1'b1;
    cyc();
    cyc();
    tgt_valid = 1'b0;
    push_ramp(100, 0, -50, 0, 0);
    repeat (13) check_tick();
    chk("brake_idle_ready", tgt_ready, 0);
    chk("brake_idle_busy", busy, 0);
    en = 1'b1;
    #1;
    chk("brake_release_ready", tgt_ready, 1);

    // Clamp
    send(5000, -5000);
    push_ramp(0, VMAX, 0, -VMAX, 0);
    repeat (125) check_tick();

    // Synchronous clear
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_speedL", $signed(speed_l), 0);
    chk("clr_speedR", $signed(speed_r), 0);
    chk("clr_busy", busy, 0);
    chk("clr_tick", tick, 0);
    chk("clr_ready", tgt_ready, 1);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("clr_div_tick", tick, (k == 9));
    end

    // Retarget mid-ramp
    send(100, 0);
    push_ramp(0, 100, 0, 0, 5);
    repeat (5) check_tick();
    send(0, 0);
    push_ramp(40, 0, 0, 0, 0);
    repeat (5) check_tick();

    // Accept coincident with a tick steps toward the old target
    send(100, 0);
    push_ramp(0, 100, 0, 0, 3);
    repeat (3) check_tick();
    repeat (9) cyc();
    chk("coinc_tick", tick, 1);
    send(0, 0);
    q.push_back('{32, 0, 1'b1});
    pop_check();
    push_ramp(32, 0, 0, 0, 0);
    repeat (4) check_tick();

    // Asynchronous reset mid-ramp
    send(100, 0);
    push_ramp(0, 100, 0, 0, 6);
    repeat (6) check_tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_speedL", $signed(speed_l), 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", tgt_ready, 1);
    chk("arst_tick", tick, 0);
    #3;
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("arst_div_tick", tick, (k == 9));
    end
    chk("arst_final_speedL", $signed(speed_l), 0);
    chk("arst_final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
